// File: rtl/nms_stream_pipe_pkg.sv
// Shared types and helpers for the pipelined non-max suppression stage.
// Holds the classification enum, tie-rule selectors and the direction lookup.
// Combinational content only; no latency or flow control of its own.
package nms_stream_pipe_pkg;

  // Edge classification carried on out_class; 2'b11 is never produced.
  typedef enum logic [1:0] {
    NONE   = 2'b00,
    WEAK   = 2'b01,
    STRONG = 2'b10
  } nms_class_t;

  // Tie rules for the centre-vs-neighbour comparison.
  localparam int TIE_LEGACY = 0;  // suppress if centre <= either neighbour
  localparam int TIE_STRICT = 1;  // suppress only if centre < either neighbour
  localparam int TIE_ASYM   = 2;  // < high-index side, <= low-index side

  // Window geometry: 3x3 row-major, pixel 4 is the centre.
  localparam int NUM_PIX  = 9;
  localparam int CENTRE_K = 4;

  // Pixel indices of the two neighbours along the gradient direction.
  typedef struct packed {
    logic [3:0] lo_k;
    logic [3:0] hi_k;
  } nms_pair_t;

  function automatic nms_pair_t nms_pair(input logic [1:0] dir);
    nms_pair_t p;
    case (dir)
      2'b00:   begin p.lo_k = 4'd3; p.hi_k = 4'd5; end  // horizontal
      2'b01:   begin p.lo_k = 4'd0; p.hi_k = 4'd8; end  // main diagonal
      2'b10:   begin p.lo_k = 4'd1; p.hi_k = 4'd7; end  // vertical
      default: begin p.lo_k = 4'd2; p.hi_k = 4'd6; end  // anti-diagonal
    endcase
    return p;
  endfunction

endpackage

// File: rtl/nms_stream_pipe_if.sv
// Stream bundle for the NMS stage: input window beat and output pixel beat.
// No logic; latency is defined by the module that owns the slave side.
// Valid/ready on both directions; the slave drives in_ready and out_valid.
interface nms_stream_pipe_if #(
  parameter int MAG_W = 11
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [9*MAG_W-1:0]   in_window;
  logic [1:0]           in_direction;
  logic                 in_last;

  logic                 out_valid;
  logic                 out_ready;
  logic [MAG_W-1:0]     out_magnitude;
  logic [1:0]           out_direction;
  logic [1:0]           out_class;
  logic                 out_last;

  // Producer of input beats and consumer of output beats.
  modport master (
    output in_valid, in_window, in_direction, in_last, out_ready,
    input  in_ready, out_valid, out_magnitude, out_direction, out_class, out_last
  );

  // The NMS pipeline itself.
  modport slave (
    input  in_valid, in_window, in_direction, in_last, out_ready,
    output in_ready, out_valid, out_magnitude, out_direction, out_class, out_last
  );

endinterface

// File: rtl/nms_stream_pipe_reg_slice.sv
// Generic valid/ready register slice of parametrised payload width.
// Latency 1 cycle; full throughput, empty slots are refilled immediately.
// in_rdy_o = !valid | out_rdy_i, so a stall propagates back combinationally.
module nms_reg_slice #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  assign in_rdy_o  = !vld_q || out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  // Load a new beat whenever the slot is free or being drained; hold otherwise.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_rdy_o) begin
      vld_d = in_vld_i;
      if (in_vld_i) dat_d = in_dat_i;
    end
  end

  // Slot state; reset drops any beat in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/nms_stream_pipe.sv
// Pipelined non-max suppression with double-threshold classification and frame edge count.
// Latency 2 cycles (suppress in S1, classify in S2); 1 beat/cycle throughput.
// Two register slices; in_ready falls only when both stages hold beats and out_ready is low.
module nms_stream_pipe
  import nms_stream_pipe_pkg::*;
#(
  parameter int MAG_W    = 11,
  parameter int TIE_MODE = 0,
  parameter int CNT_W    = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  nms_stream_pipe_if.slave  strm,
  input  logic [MAG_W-1:0]  thresh_low,
  input  logic [MAG_W-1:0]  thresh_high,
  output logic [CNT_W-1:0]  edge_count,
  output logic              edge_count_valid
);

  // S1 carries the frame thresholds with each beat so a frame boundary in
  // flight never classifies a beat against the next frame's thresholds.
  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] thr_lo;
    logic [MAG_W-1:0] thr_hi_eff;
    logic [1:0]       dir;
    logic             last;
  } s1_t;

  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic [1:0]       dir;
    nms_class_t       cls;
    logic             last;
  } s2_t;

  // ---------------- input side: suppression and threshold capture ----------
  nms_pair_t        pair;
  logic [MAG_W-1:0] centre, nb_lo, nb_hi;
  logic             suppress;
  logic             in_xfer;

  logic             frame_start_q, frame_start_d;
  logic [MAG_W-1:0] thr_lo_q, thr_lo_d;
  logic [MAG_W-1:0] thr_hi_q, thr_hi_d;
  logic [MAG_W-1:0] thr_lo_use, thr_hi_use;

  s1_t              s1_in, s1_out;
  logic             s1_out_vld, s2_in_rdy;

  assign in_xfer = strm.in_valid && strm.in_ready;

  // Pick the neighbour pair and apply the selected tie rule to the centre.
  always_comb begin
    pair   = nms_pair(strm.in_direction);
    centre = strm.in_window[CENTRE_K*MAG_W +: MAG_W];
    nb_lo  = strm.in_window[pair.lo_k*MAG_W +: MAG_W];
    nb_hi  = strm.in_window[pair.hi_k*MAG_W +: MAG_W];
    case (TIE_MODE)
      TIE_STRICT: suppress = (centre <  nb_lo) || (centre <  nb_hi);
      TIE_ASYM:   suppress = (centre <= nb_lo) || (centre <  nb_hi);
      default:    suppress = (centre <= nb_lo) || (centre <= nb_hi);
    endcase
  end

  // First beat of a frame uses the live threshold inputs; later beats the captured ones.
  always_comb begin
    thr_lo_use    = frame_start_q ? thresh_low  : thr_lo_q;
    thr_hi_use    = frame_start_q ? thresh_high : thr_hi_q;
    thr_lo_d      = thr_lo_q;
    thr_hi_d      = thr_hi_q;
    frame_start_d = frame_start_q;
    if (in_xfer) begin
      frame_start_d = strm.in_last;
      if (frame_start_q) begin
        thr_lo_d = thresh_low;
        thr_hi_d = thresh_high;
      end
    end
  end

  // Assemble the S1 payload; low > high collapses to a single threshold at low.
  always_comb begin
    s1_in            = '0;
    s1_in.mag        = suppress ? '0 : centre;
    s1_in.thr_lo     = thr_lo_use;
    s1_in.thr_hi_eff = (thr_hi_use > thr_lo_use) ? thr_hi_use : thr_lo_use;
    s1_in.dir        = strm.in_direction;
    s1_in.last       = strm.in_last;
  end

  // Frame-start flag and per-frame threshold registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_start_q <= 1'b1;
      thr_lo_q      <= '0;
      thr_hi_q      <= '0;
    end else begin
      frame_start_q <= frame_start_d;
      thr_lo_q      <= thr_lo_d;
      thr_hi_q      <= thr_hi_d;
    end
  end

  nms_reg_slice #(.W($bits(s1_t))) u_s1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_vld_i  (strm.in_valid),
    .in_rdy_o  (strm.in_ready),
    .in_dat_i  (s1_in),
    .out_vld_o (s1_out_vld),
    .out_rdy_i (s2_in_rdy),
    .out_dat_o (s1_out)
  );

  // ---------------- S1 -> S2: classification --------------------------------
  s2_t s2_in, s2_out;
  logic s2_out_vld;

  // Zero magnitude is always NONE; otherwise strong beats weak beats none.
  always_comb begin
    s2_in      = '0;
    s2_in.mag  = s1_out.mag;
    s2_in.dir  = s1_out.dir;
    s2_in.last = s1_out.last;
    s2_in.cls  = NONE;
    if (s1_out.mag != '0) begin
      if (s1_out.mag >= s1_out.thr_hi_eff)  s2_in.cls = STRONG;
      else if (s1_out.mag >= s1_out.thr_lo) s2_in.cls = WEAK;
    end
  end

  nms_reg_slice #(.W($bits(s2_t))) u_s2 (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_vld_i  (s1_out_vld),
    .in_rdy_o  (s2_in_rdy),
    .in_dat_i  (s2_in),
    .out_vld_o (s2_out_vld),
    .out_rdy_i (strm.out_ready),
    .out_dat_o (s2_out)
  );

  assign strm.out_valid     = s2_out_vld;
  assign strm.out_magnitude = s2_out.mag;
  assign strm.out_direction = s2_out.dir;
  assign strm.out_class     = s2_out.cls;
  assign strm.out_last      = s2_out.last;

  // ---------------- per-frame edge counter ----------------------------------
  logic             out_xfer, contrib;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;
  logic [CNT_W-1:0] ec_q, ec_d;
  logic             ecv_q, ecv_d;

  assign out_xfer = s2_out_vld && strm.out_ready;
  assign contrib  = (s2_out.cls != NONE);

  // Saturating count; the last beat reports its own contribution and restarts the count.
  always_comb begin
    cnt_sum = cnt_q;
    if (contrib && (cnt_q != {CNT_W{1'b1}})) cnt_sum = cnt_q + CNT_W'(1);
    cnt_d = cnt_q;
    ec_d  = ec_q;
    ecv_d = 1'b0;
    if (out_xfer) begin
      if (s2_out.last) begin
        ec_d  = cnt_sum;
        ecv_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_sum;
      end
    end
  end

  // Counter, reported count and its one-cycle valid pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ec_q  <= '0;
      ecv_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ec_q  <= ec_d;
      ecv_q <= ecv_d;
    end
  end

  assign edge_count       = ec_q;
  assign edge_count_valid = ecv_q;

endmodule

// File: tb/tb_nms_stream_pipe.sv
// Directed bench for nms_stream_pipe: tie rules, latency, backpressure, framing, reset.
// Three instances share one stimulus stream, differing only in TIE_MODE.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_nms_stream_pipe;
  import nms_stream_pipe_pkg::*;

  localparam int MAG_W = 11;
  localparam int CNT_W = 20;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset_n;
  logic                 in_valid, in_last, out_ready;
  logic [9*MAG_W-1:0]   in_window;
  logic [1:0]           in_direction;
  logic [MAG_W-1:0]     thresh_low, thresh_high;
  logic [CNT_W-1:0]     ec0, ec1, ec2;
  logic                 ecv0, ecv1, ecv2;

  nms_stream_pipe_if #(.MAG_W(MAG_W)) if0 ();
  nms_stream_pipe_if #(.MAG_W(MAG_W)) if1 ();
  nms_stream_pipe_if #(.MAG_W(MAG_W)) if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.in_window = in_window; assign if1.in_window = in_window; assign if2.in_window = in_window;
  assign if0.in_direction = in_direction; assign if1.in_direction = in_direction; assign if2.in_direction = in_direction;
  assign if0.in_last = in_last;    assign if1.in_last = in_last;    assign if2.in_last = in_last;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  nms_stream_pipe #(.MAG_W(MAG_W), .TIE_MODE(TIE_LEGACY), .CNT_W(CNT_W)) dut0 (
    .clock(clock), .reset_n(reset_n), .strm(if0), .thresh_low(thresh_low),
    .thresh_high(thresh_high), .edge_count(ec0), .edge_count_valid(ecv0));
  nms_stream_pipe #(.MAG_W(MAG_W), .TIE_MODE(TIE_STRICT), .CNT_W(CNT_W)) dut1 (
    .clock(clock), .reset_n(reset_n), .strm(if1), .thresh_low(thresh_low),
    .thresh_high(thresh_high), .edge_count(ec1), .edge_count_valid(ecv1));
  nms_stream_pipe #(.MAG_W(MAG_W), .TIE_MODE(TIE_ASYM), .CNT_W(CNT_W)) dut2 (
    .clock(clock), .reset_n(reset_n), .strm(if2), .thresh_low(thresh_low),
    .thresh_high(thresh_high), .edge_count(ec2), .edge_count_valid(ecv2));

  int vecs  = 0;
  int fails = 0;

  int m4[4] = '{250, 150, 50, 120};
  int c4[4] = '{2, 1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_beat(input int c, input int dir, input int lo_k, input int lo_v,
                          input int hi_k, input int hi_v, input logic last);
    in_window = '0;
    in_window[4*MAG_W +: MAG_W]    = MAG_W'(c);
    in_window[lo_k*MAG_W +: MAG_W] = MAG_W'(lo_v);
    in_window[hi_k*MAG_W +: MAG_W] = MAG_W'(hi_v);
    in_direction = 2'(dir);
    in_last      = last;
    in_valid     = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, oidx;
    logic saw_stall, hold, in_x;
    logic [MAG_W-1:0] held;

    reset_n = 1'b0; in_valid = 1'b0; in_window = '0; in_direction = 2'd0;
    in_last = 1'b0; out_ready = 1'b1; thresh_low = '0; thresh_high = '0;
    #2;
    chk("rst_out_valid", 32'(if0.out_valid), 0);
    chk("rst_out_mag",   32'(if0.out_magnitude), 0);
    chk("rst_out_class", 32'(if0.out_class), 0);
    chk("rst_out_last",  32'(if0.out_last), 0);
    chk("rst_out_dir",   32'(if0.out_direction), 0);
    chk("rst_ecv",       32'(ecv0), 0);
    chk("rst_ec",        32'(ec0), 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // 1: tie rules on centre=100, k3=100 (low side), k5=50.
    thresh_low = 11'd10; thresh_high = 11'd20;
    set_beat(100, 0, 3, 100, 5, 50, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t1_lat_not_yet", 32'(if0.out_valid), 0);
    step();
    chk("t1_lat_valid",    32'(if0.out_valid), 1);
    chk("t1_legacy_mag",   32'(if0.out_magnitude), 0);
    chk("t1_legacy_class", 32'(if0.out_class), 0);
    chk("t1_strict_mag",   32'(if1.out_magnitude), 100);
    chk("t1_strict_class", 32'(if1.out_class), 2);
    chk("t1_asym_mag",     32'(if2.out_magnitude), 0);
    chk("t1_last",         32'(if0.out_last), 1);
    step();
    chk("t1_ecv",        32'(ecv0), 1);
    chk("t1_ec_legacy",  32'(ec0), 0);
    chk("t1_ec_strict",  32'(ec1), 1);
    step();
    chk("t1_ecv_pulse",  32'(ecv0), 0);

    // 2: diagonal 11, centre 300 vs k2=299, k6=12, thresholds 100/250.
    thresh_low = 11'd100; thresh_high = 11'd250;
    set_beat(300, 3, 2, 299, 6, 12, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t2_lat_not_yet", 32'(if0.out_valid), 0);
    step();
    chk("t2_valid", 32'(if0.out_valid), 1);
    chk("t2_mag",   32'(if0.out_magnitude), 300);
    chk("t2_class", 32'(if0.out_class), 2);
    chk("t2_dir",   32'(if0.out_direction), 3);
    step();
    chk("t2_ecv", 32'(ecv0), 1);
    chk("t2_ec",  32'(ec0), 1);
    step();

    // 3: six beats under out_ready pattern 1,0,0 repeating.
    thresh_low = '0; thresh_high = '0;
    idx = 0; oidx = 0; saw_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && oidx < 6; cyc++) begin
      out_ready = (cyc % 3 == 0);
      if (idx < 6) set_beat(10 * (idx + 1), 0, 3, 0, 5, 0, idx == 5);
      else in_valid = 1'b0;
      #1;
      if (in_valid && !if0.in_ready) saw_stall = 1'b1;
      in_x = in_valid && if0.in_ready;
      hold = if0.out_valid && !out_ready;
      held = if0.out_magnitude;
      if (if0.out_valid && out_ready) begin
        chk("t3_order", 32'(if0.out_magnitude), 10 * (oidx + 1));
        oidx++;
      end
      step();
      if (hold) begin
        chk("t3_hold_valid", 32'(if0.out_valid), 1);
        chk("t3_hold_mag",   32'(if0.out_magnitude), 32'(held));
      end
      if (in_x) idx++;
    end
    chk("t3_beats_out", 32'(oidx), 6);
    chk("t3_in_ready_low", 32'(saw_stall), 1);
    chk("t3_ecv", 32'(ecv0), 1);
    chk("t3_ec",  32'(ec0), 6);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    // 4: frame strong, weak, none, weak; thresholds altered mid-frame.
    thresh_low = 11'd100; thresh_high = 11'd200;
    for (int j = 0; j < 4; j++) begin
      set_beat(m4[j], 0, 3, 0, 5, 0, j == 3);
      step();
      if (j == 0) begin thresh_low = '0; thresh_high = '0; end
      chk("t4_no_early_ecv", 32'(ecv0), 0);
      if (j >= 1) chk("t4_class", 32'(if0.out_class), c4[j-1]);
    end
    in_valid = 1'b0;
    step();
    chk("t4_class_last", 32'(if0.out_class), c4[3]);
    chk("t4_last",       32'(if0.out_last), 1);
    step();
    chk("t4_ecv", 32'(ecv0), 1);
    chk("t4_ec",  32'(ec0), 3);
    step();
    chk("t4_ecv_single", 32'(ecv0), 0);
    set_beat(50, 0, 3, 0, 5, 0, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    chk("t4_next_frame_thr", 32'(if0.out_class), 2);
    step(); step();

    // 5: low > high degenerates to a single threshold at low.
    thresh_low = 11'd200; thresh_high = 11'd150;
    set_beat(180, 0, 3, 0, 5, 0, 1'b0);
    step();
    set_beat(200, 0, 3, 0, 5, 0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t5_180_class", 32'(if0.out_class), 0);
    step();
    chk("t5_200_class", 32'(if0.out_class), 2);
    step();
    chk("t5_ecv", 32'(ecv0), 1);
    chk("t5_ec",  32'(ec0), 1);
    step();

    // 6: reset with two beats in flight, then re-sample thresholds.
    thresh_low = 11'd10; thresh_high = 11'd20;
    set_beat(500, 0, 3, 0, 5, 0, 1'b0);
    step();
    set_beat(600, 0, 3, 0, 5, 0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t6_inflight", 32'(if0.out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(if0.out_valid), 0);
    chk("t6_rst_ec",    32'(ec0), 0);
    step();
    chk("t6_rst_no_ecv", 32'(ecv0), 0);
    step();
    chk("t6_rst_still_empty", 32'(if0.out_valid), 0);
    reset_n = 1'b1;
    thresh_low = 11'd400; thresh_high = 11'd700;
    set_beat(500, 0, 3, 0, 5, 0, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    chk("t6_resample_class", 32'(if0.out_class), 1);
    chk("t6_resample_mag",   32'(if0.out_magnitude), 500);
    step();
    chk("t6_ecv", 32'(ecv0), 1);
    chk("t6_ec",  32'(ec0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/nms_stream_pipe.md
Name: nms_stream_pipe

Overview:
- Parametrised, pipelined successor to the combinational non-max suppression stage in the edge-detection datapath.
- Accepts one 3x3 gradient-magnitude window plus a quantised direction per beat over a valid/ready stream.
- Thins the centre magnitude against its two direction neighbours using a selectable tie rule, then classifies survivors as strong, weak or none against run-time double thresholds.
- Sits between the gradient stage and the hysteresis/edge-tracking stage. It also reports a per-frame edge count.

Parameters:
- MAG_W, 11: magnitude width in bits.
- TIE_MODE, 0: tie rule. 0 = legacy (suppress if centre <= either neighbour). 1 = strict (suppress only if centre < either neighbour). 2 = asymmetric (suppress if centre < high-index neighbour or centre <= low-index neighbour).
- CNT_W, 20: width of the per-frame edge counter.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_window  input  9*MAG_W  3x3 window; pixel k at [k*MAG_W +: MAG_W]; k=4 is centre; row-major, k=0 top-left
- in_direction  input  2  quantised direction of centre
- in_last  input  1  final beat of frame
- thresh_low  input  MAG_W  weak threshold
- thresh_high  input  MAG_W  strong threshold
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_magnitude  output  MAG_W  thinned magnitude (0 if suppressed)
- out_direction  output  2  direction passed through
- out_class  output  2  00 none, 01 weak, 10 strong (11 never driven)
- out_last  output  1  in_last passed through
- edge_count  output  CNT_W  count of weak+strong beats in the completed frame
- edge_count_valid  output  1  one-cycle pulse; edge_count is valid

Behaviour:
- Reset (reset_n low, asynchronous):
  - Outputs: out_valid=0, edge_count_valid=0, edge_count=0, out_magnitude=0, out_class=00, out_last=0, out_direction=0.
  - Internal: counter=0, threshold regs=0, frame-start flag=1.
  - Beats in flight when reset asserts are discarded.
- Neighbour pairs, listed as (low index, high index):
  - dir 00 = (3,5)
  - dir 01 = (0,8)
  - dir 10 = (1,7)
  - dir 11 = (2,6)
  - All fields are exactly MAG_W wide; comparisons are unsigned.
- Stage 1 (S1): on transfer (in_valid & in_ready), register the centre, direction, last, and a suppress bit computed per TIE_MODE. Registered magnitude = suppress ? 0 : centre.
- Thresholds:
  - Sampled into internal regs on the first transfer of a frame, i.e. when frame-start flag=1 (flag set by reset and by any in_last transfer, cleared by any other transfer).
  - Held constant for the rest of the frame.
  - Effective high = max(low, high). Low > high degenerates to a single threshold at low.
- Stage 2 (S2): classify the S1 magnitude using the frame thresholds:
  - mag=0 -> none
  - mag >= high_eff -> strong
  - mag >= low -> weak
  - else -> none
  - Magnitude is passed unmodified; suppression already zeroed it.
- Latency: 2 cycles from input transfer to out_valid, when not stalled. Throughput is 1 beat/cycle.
- Handshake:
  - Each stage is a register slice: stage_ready = !stage_valid | next_ready. in_ready = S1 ready.
  - Bubbles collapse.
  - out_* holds stable while out_valid & !out_ready.
  - No combinational path from in_valid to out_valid.
- Counter:
  - Increments on each output transfer with class != none, saturating at 2^CNT_W-1.
  - On an output transfer with out_last=1: edge_count <= counter plus that beat's contribution (saturated); edge_count_valid pulses the next cycle; counter clears to 0 in the same update.
  - Last beat of frame N and first beat of frame N+1 in adjacent cycles: no beat is lost or double-counted.
- Frame of a single beat (in_last on the first beat): thresholds sampled and count reported from that one beat.

Decomposition:
- definitions_pkg gains:
  - nms_class_t enum (NONE, WEAK, STRONG)
  - TIE_LEGACY/TIE_STRICT/TIE_ASYM constants
  - neighbour-index lookup function nms_pair(dir) returning low/high k
- Sub-module nms_reg_slice (parametrised-width valid/ready register), instantiated for S1 and S2.
- Compare, classify and counter logic stay in nms_stream_pipe.

Test Plan:
1. MAG_W=11, TIE_MODE=0, dir 00, centre=100, k3=100, k5=50 -> out_magnitude=0, class none. Same beat with TIE_MODE=1 -> 100; with TIE_MODE=2 (k3 is low side, <=) -> 0.
2. dir 11, centre=300, k2=299, k6=12, thresholds low=100/high=250 -> out_magnitude=300, class strong, out_valid exactly 2 cycles after transfer.
3. Backpressure: stream 6 beats with out_ready toggling 1,0,0,1,… -> all 6 appear in order, outputs stable during stall, in_ready deasserts when both stages are full.
4. Frame of 4 beats classified strong, weak, none, weak with in_last on beat 4 -> edge_count=3, edge_count_valid single pulse. A thresh change mid-frame has no effect until the next frame.
5. thresh_low=200, thresh_high=150, centre survivor=180 -> class none. Survivor 200 -> strong.
6. Assert reset_n low with 2 beats in flight -> out_valid=0 immediately, no edge_count_valid. After release, the first beat re-samples thresholds.
